// File: rtl/rc4_xor_stream.sv
// XORs a byte stream with RC4 keystream bytes drawn from a small prefetch FIFO.
// Symmetric: the same block encrypts and decrypts; each message runs start -> done.
module rc4_xor_stream #(
    parameter int KS_DEPTH = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       ks_byte,
    input  logic             ks_valid,
    output logic             ks_ready,
    input  logic [7:0]       din,
    input  logic             din_valid,
    input  logic             din_last,
    output logic             din_ready,
    output logic [7:0]       dout,
    output logic             dout_valid,
    output logic             dout_last,
    input  logic             dout_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] byte_cnt
);
    localparam int PTR_W = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
    localparam logic [PTR_W:0] FIFO_FULL = (PTR_W + 1)'(KS_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DRAIN
    } state_t;

    state_t           state_reg, state_next;

    logic [7:0]       ks_mem [KS_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]   count_reg;

    logic [7:0]       dout_reg;
    logic             dout_valid_reg, dout_last_reg, done_reg;
    logic [CNT_W-1:0] byte_cnt_reg;

    logic start_go, flush, push, pop, out_take, msg_end;

    // ks_ready looks only at the registered count, so a full FIFO can never be pushed.
    assign start_go = start && (state_reg == ST_IDLE) && !abort;
    assign flush    = abort || start_go;
    assign ks_ready = (state_reg == ST_ACTIVE) && (count_reg < FIFO_FULL);
    assign din_ready = (state_reg == ST_ACTIVE) && (count_reg != '0) &&
                       (!dout_valid_reg || dout_ready);
    assign push     = ks_valid && ks_ready && !abort;
    assign pop      = din_valid && din_ready && !abort;
    assign out_take = dout_valid_reg && dout_ready;
    assign msg_end  = (state_reg == ST_DRAIN) && out_take && dout_last_reg && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:   if (start) state_next = ST_ACTIVE;
                ST_ACTIVE: if (pop && din_last) state_next = ST_DRAIN;
                ST_DRAIN:  if (out_take && dout_last_reg) state_next = ST_IDLE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    // Storage needs no reset: emptiness is tracked by count_reg alone.
    always_ff @(posedge clk) begin
        if (push) begin
            ks_mem[wr_ptr_reg] <= ks_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            dout_last_reg  <= 1'b0;
        end else if (abort) begin
            dout_valid_reg <= 1'b0;
            dout_last_reg  <= 1'b0;
        end else if (pop) begin
            dout_reg       <= din ^ ks_mem[rd_ptr_reg];
            dout_last_reg  <= din_last;
            dout_valid_reg <= 1'b1;
        end else if (out_take) begin
            dout_valid_reg <= 1'b0;
        end
    end

    // Abort leaves byte_cnt untouched so software can see how far the message got.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_reg <= '0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= msg_end;
            if (start_go) begin
                byte_cnt_reg <= '0;
            end else if (pop) begin
                byte_cnt_reg <= byte_cnt_reg + 1'b1;
            end
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign dout_last  = dout_last_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign done       = done_reg;
    assign byte_cnt   = byte_cnt_reg;

endmodule

// File: tb/tb_rc4_xor_stream.sv
// Randomized self-checking bench for rc4_xor_stream against a queue-based model
// of keystream consumption, output handshaking and message lifecycle.
module tb_rc4_xor_stream;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0;
    logic [7:0]  ks_byte = '0;
    logic        ks_valid = 1'b0;
    logic        ks_ready;
    logic [7:0]  din = '0;
    logic        din_valid = 1'b0, din_last = 1'b0;
    logic        din_ready;
    logic [7:0]  dout;
    logic        dout_valid, dout_last;
    logic        dout_ready = 1'b1;
    logic        busy, done;
    logic [15:0] byte_cnt;

    rc4_xor_stream #(.KS_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .ks_byte(ks_byte), .ks_valid(ks_valid), .ks_ready(ks_ready),
        .din(din), .din_valid(din_valid), .din_last(din_last), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last), .dout_ready(dout_ready),
        .busy(busy), .done(done), .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: keystream bytes in the FIFO, output bytes not yet taken.
    logic [7:0]  ks_q[$];
    logic [8:0]  exp_q[$];
    logic [7:0]  out_log[$];
    bit          m_busy = 0, m_active = 0, m_done = 0, prev_stall = 0;
    logic [7:0]  prev_dout = '0;
    logic [15:0] m_cnt = '0;
    int          done_cnt = 0;

    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst_n) begin
            ks_q.delete(); exp_q.delete();
            m_busy = 0; m_active = 0; m_done = 0; prev_stall = 0; m_cnt = '0;
        end else begin
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("byte_cnt", 32'(byte_cnt), 32'(m_cnt));
            check("ks_ready", 32'(ks_ready), 32'(m_active && ks_q.size() < 4));
            check("din_ready", 32'(din_ready),
                  32'(m_active && ks_q.size() > 0 && (exp_q.size() == 0 || dout_ready)));
            check("dout_valid", 32'(dout_valid), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                check("dout", 32'(dout), 32'(e[7:0]));
                check("dout_last", 32'(dout_last), 32'(e[8]));
            end
            if (prev_stall) check("dout_hold", 32'(dout), 32'(prev_dout));
            if (done) done_cnt++;

            m_done     = 0;
            prev_stall = dout_valid && !dout_ready && !abort;
            prev_dout  = dout;
            if (abort) begin
                m_busy = 0; m_active = 0;
                ks_q.delete(); exp_q.delete();
            end else if (!m_busy && start) begin
                m_busy = 1; m_active = 1; m_cnt = '0;
                ks_q.delete();
            end else begin
                if (dout_valid && dout_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    out_log.push_back(e[7:0]);
                    if (e[8]) begin m_busy = 0; m_done = 1; end
                end
                if (din_valid && din_ready && ks_q.size() > 0) begin
                    exp_q.push_back({din_last, din ^ ks_q.pop_front()});
                    m_cnt++;
                    if (din_last) m_active = 0;
                end
                if (ks_valid && ks_ready) ks_q.push_back(ks_byte);
            end
        end
    end

    logic [7:0] ks_arr[64];
    logic [7:0] din_arr[64];

    task automatic idle(input int k);
        ks_valid = 0; din_valid = 0; din_last = 0; dout_ready = 1;
        repeat (k) begin @(posedge clk); #1; end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ks_ready"}, 32'(ks_ready), 0);
        check({tag, "_din_ready"}, 32'(din_ready), 0);
        check({tag, "_dout_valid"}, 32'(dout_valid), 0);
        check({tag, "_dout_last"}, 32'(dout_last), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_dout"}, 32'(dout), 0);
        check({tag, "_byte_cnt"}, 32'(byte_cnt), 0);
    endtask

    // rdy_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random. Entry/exit at posedge+1.
    task automatic run_msg(input int n, input int ks_len, input int ks_pct, input int din_pct,
                           input int rdy_mode, input int stall_at, input int abort_at,
                           output bit aborted);
        int ks_i = 0, d_i = 0, out_n = 0, cyc = 0;
        bit stalled;
        logic [5:0] ki, di;
        aborted = 0;
        out_log.delete();
        done_cnt = 0;
        start = 1;
        @(posedge clk); #1 start = 0;
        while (out_n < n && cyc < 1000) begin
            stalled  = (stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + 10);
            ki = 6'(ks_i); di = 6'(d_i);
            ks_valid = (ks_i < ks_len) && !stalled && ($urandom_range(99) < ks_pct);
            ks_byte  = ks_arr[ki];
            din_valid = (d_i < n) && ($urandom_range(99) < din_pct);
            din      = din_arr[di];
            din_last = (d_i == n - 1);
            case (rdy_mode)
                0:       dout_ready = 1;
                1:       dout_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: dout_ready = ($urandom_range(99) < 60);
            endcase
            abort = (abort_at >= 0) && (d_i == abort_at);
            @(negedge clk);
            if (!abort) begin
                if (ks_valid && ks_ready) ks_i++;
                if (din_valid && din_ready) d_i++;
                if (dout_valid && dout_ready) out_n++;
            end
            @(posedge clk); #1;
            if (abort) begin
                abort = 0;
                aborted = 1;
                break;
            end
            cyc++;
        end
        ks_valid = 0; din_valid = 0; din_last = 0;
        if (!aborted) check("msg_complete", 32'(out_n), 32'(n));
    endtask

    initial begin
        bit ab;
        int pushes, n;
        #3 check_reset_vals("rst");
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk); #1;

        // Known vector "Plai"
        ks_arr[0] = 8'hEB; ks_arr[1] = 8'h9F; ks_arr[2] = 8'h77; ks_arr[3] = 8'h81;
        din_arr[0] = 8'h50; din_arr[1] = 8'h6C; din_arr[2] = 8'h61; din_arr[3] = 8'h69;
        for (int m = 0; m < 2; m++) begin
            run_msg(4, 4, 100, 100, m, -1, -1, ab);
            idle(3);
            check("vec_len", 32'(out_log.size()), 4);
            if (out_log.size() == 4) begin
                check("vec_b0", 32'(out_log[0]), 32'hBB);
                check("vec_b1", 32'(out_log[1]), 32'hF3);
                check("vec_b2", 32'(out_log[2]), 32'h16);
                check("vec_b3", 32'(out_log[3]), 32'hE8);
            end
            check("vec_cnt", 32'(byte_cnt), 4);
            check("vec_done", 32'(done_cnt), 1);
            $display("msg vector rdy_mode=%0d bytes=%0d", m, out_log.size());
        end

        // Keystream stall mid-message
        for (int i = 0; i < 64; i++) begin ks_arr[i] = 8'($urandom); din_arr[i] = 8'($urandom); end
        run_msg(8, 10, 100, 100, 0, 3, -1, ab);
        idle(3);
        check("stall_done", 32'(done_cnt), 1);
        $display("msg ks_stall bytes=%0d", out_log.size());

        // Single byte
        ks_arr[0] = 8'h5A; din_arr[0] = 8'h00;
        run_msg(1, 1, 100, 100, 0, -1, -1, ab);
        idle(3);
        check("single_len", 32'(out_log.size()), 1);
        if (out_log.size() == 1) check("single_byte", 32'(out_log[0]), 32'h5A);
        check("single_done", 32'(done_cnt), 1);
        check("single_idle", 32'(busy), 0);
        $display("msg single bytes=%0d", out_log.size());

        // Abort after 2 of 4
        for (int i = 0; i < 8; i++) begin ks_arr[i] = 8'($urandom); din_arr[i] = 8'($urandom); end
        run_msg(4, 6, 100, 100, 0, -1, 2, ab);
        check("abort_taken", 32'(ab), 1);
        check("abort_busy", 32'(busy), 0);
        check("abort_dout_valid", 32'(dout_valid), 0);
        idle(3);
        check("abort_cnt", 32'(byte_cnt), 2);
        check("abort_no_done", 32'(done_cnt), 0);
        $display("msg abort bytes_out=%0d", out_log.size());
        run_msg(4, 4, 100, 100, 0, -1, -1, ab);
        idle(3);
        check("post_abort_done", 32'(done_cnt), 1);
        check("post_abort_cnt", 32'(byte_cnt), 4);
        $display("msg post_abort bytes=%0d", out_log.size());

        // FIFO fill then asynchronous reset
        start = 1;
        @(posedge clk); #1 start = 0;
        ks_valid = 1; din_valid = 0; pushes = 0;
        repeat (8) begin
            ks_byte = 8'($urandom);
            @(negedge clk);
            if (ks_valid && ks_ready) pushes++;
            @(posedge clk); #1;
        end
        check("fill_pushes", 32'(pushes), 4);
        check("fill_ks_ready", 32'(ks_ready), 0);
        check("fill_busy", 32'(busy), 1);
        $display("msg fifo_fill pushes=%0d", pushes);
        #1 rst_n = 0;
        #1 check_reset_vals("async_rst");
        ks_valid = 0;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk); #1;

        // Randomized messages
        for (int m = 0; m < 25; m++) begin
            int ab_at;
            n = $urandom_range(1, 16);
            for (int i = 0; i < 64; i++) begin ks_arr[i] = 8'($urandom); din_arr[i] = 8'($urandom); end
            ab_at = ($urandom_range(4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            run_msg(n, n + $urandom_range(0, 5), $urandom_range(30, 100), $urandom_range(30, 100),
                    2, ($urandom_range(3) == 0) ? 2 : -1, ab_at, ab);
            idle(3);
            check("rand_done", 32'(done_cnt), ab ? 0 : 1);
            $display("msg random %0d n=%0d aborted=%0d bytes_out=%0d", m, n, ab, out_log.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rc4_xor_stream.md
# rc4_xor_stream

Consumer end of the RC4 keystream interface: it takes keystream bytes from the RC4 generator through a small prefetch FIFO and XORs them byte-for-byte with a data stream. Because XOR is symmetric, the same block encrypts and decrypts. It sits between the keystream generator and the byte-wide data path. Each message runs from a `start` pulse to a one-cycle `done` pulse.

## Interface
- `KS_DEPTH`, default 4: keystream FIFO depth in bytes; a power of two, at least 2.
- `CNT_W`, default 16: width of the processed-byte counter.

Ports:
- `clk` in 1: sole clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse that begins a message; honoured only in IDLE.
- `abort` in 1: synchronous cancel of the current message.
- `ks_byte` in 8: keystream byte from the generator.
- `ks_valid` in 1: `ks_byte` is valid.
- `ks_ready` out 1: FIFO accepts a keystream byte this cycle.
- `din` in 8: plaintext or ciphertext byte.
- `din_valid` in 1: `din` is valid.
- `din_last` in 1: `din` is the final byte of the message.
- `din_ready` out 1: block accepts a `din` byte this cycle.
- `dout` out 8: result byte, `din` XOR keystream.
- `dout_valid` out 1: `dout` is valid.
- `dout_last` out 1: `dout` is the final byte of the message.
- `dout_ready` in 1: downstream takes `dout`.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse when the last output byte has been taken.
- `byte_cnt` out CNT_W: bytes accepted on `din` since the last `start`.

## Operation
- States:
  - IDLE: waits for `start`.
  - ACTIVE: streaming.
  - DRAIN: `din_last` has been accepted; waiting for the output register to empty.
- IDLE → ACTIVE on `start`. On this transition `byte_cnt` clears to 0 and the FIFO is emptied.
- ACTIVE → DRAIN when a `din` transfer with `din_last`=1 occurs.
- DRAIN → IDLE when `dout_valid & dout_ready & dout_last`. `done` pulses high the cycle after.
- `abort` in any state:
  - next state is IDLE, FIFO emptied, `dout_valid`/`dout_last` cleared;
  - no `done` pulse; `byte_cnt` holds its value.
  - `abort` has priority over every other event in the same cycle.
- `start` in ACTIVE or DRAIN is ignored.
- `ks_ready` = ACTIVE and FIFO count < KS_DEPTH.
  - It depends only on the registered count, never on a same-cycle pop.
  - A push when full is impossible by construction.
- `din_ready` = ACTIVE and FIFO count > 0 and (!`dout_valid` or `dout_ready`).
- On a `din` transfer, all of the following happen:
  - FIFO head pops;
  - `dout` ← `din` XOR head;
  - `dout_last` ← `din_last`;
  - `dout_valid` ← 1;
  - `byte_cnt` increments, wrapping modulo 2^CNT_W.
- If `dout_valid & dout_ready` occurs with no new transfer, `dout_valid` clears.
- Simultaneous keystream push and pop leave the count unchanged and preserve FIFO order.
- The keystream byte is consumed exactly once per data byte, in arrival order. No keystream byte is skipped or reused within a message.
- Keystream left in the FIFO at message end stays there until the next `start` or `abort` flushes it.

## Timing
- Reset values: `ks_ready`, `din_ready`, `dout_valid`, `dout_last`, `busy`, `done` = 0; `dout` = 0x00; `byte_cnt` = 0; state IDLE; FIFO empty.
- Reset asserted mid-message returns all of the above immediately, with no `done` pulse.
- Latency:
  - `start` at edge E0: `ks_ready` is high in the cycle after E0.
  - First keystream push at edge E1: `din_ready` can be high in the cycle after E1.
  - `din` accepted at edge N: `dout_valid` is high from the cycle after N.
- Throughput: one byte per cycle, sustained, when the FIFO is non-empty and `dout_ready`=1.
- `dout`, `dout_last` and `dout_valid` are registered and stay stable while `dout_valid & !dout_ready`.
- `done` is high for exactly one cycle, and that cycle is in IDLE.

## Test plan
- Key-derived keystream EB 9F 77 81, `din` 50 6C 61 69 ("Plai") with `din_last` on 69, `dout_ready`=1 → `dout` BB F3 16 E8, `dout_last` on E8, `done` one cycle later, `byte_cnt`=4.
- Same stimulus with `dout_ready` toggling 1,0,0,1 → same bytes in order; `dout` stable while stalled; `din_ready`=0 while output held and not taken.
- `ks_valid` held low for 10 cycles mid-message → `din_ready`=0 throughout, no output; resumes correctly with the next keystream bytes.
- Single-byte message `din`=0x00 with `din_last`, keystream 0x5A → `dout`=0x5A, `dout_last`=1, `done` pulse, return to IDLE.
- `abort` after 2 of 4 bytes → IDLE next cycle, `dout_valid`=0, no `done`, FIFO empty. A following `start` runs a clean message; `byte_cnt` is 2 until that `start` clears it.
- FIFO fill: `din_valid`=0, `ks_valid`=1 → exactly KS_DEPTH=4 pushes, then `ks_ready`=0. Then `rst_n` pulsed low mid-message → all outputs at reset values asynchronously.
